// File: rtl/arith_unit_seq.sv
// rtl/arith_unit_seq.sv - sequential add/sub/mul/div/mod unit with valid/ready handshakes
module arith_unit_seq #(
  parameter int N = 16,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   opcode_i,
  input  logic         signed_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic         overflow_o,
  output logic         cout_o,
  output logic         div_zero_o
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [N-1:0]   a_q, b_q, x_q;
  logic [2*N-1:0] acc_q, acc_next;
  logic [2:0]     op_q;
  logic           sgn_q, neg_res_q, a_neg_q, dz_q, min_neg_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   result_q;
  logic           ovf_q, cout_q, dz_out_q;

  logic           accept, iter_op, finish;
  logic           a_neg_in, b_neg_in, is_divmod_in;
  logic [N-1:0]   mag_a_in, mag_b_in;

  logic [N:0]     mul_sum, rem_sh, div_diff;
  logic           div_ge;
  logic [N:0]     add_sum, sub_diff, mul_hi;
  logic [2*N-1:0] product;
  logic [N-1:0]   fin_result;
  logic           fin_ovf, fin_cout, fin_dz;

  assign accept       = valid_i && (state_q == IDLE);
  assign a_neg_in     = signed_i & a_i[N-1];
  assign b_neg_in     = signed_i & b_i[N-1];
  assign mag_a_in     = a_neg_in ? -a_i : a_i;
  assign mag_b_in     = b_neg_in ? -b_i : b_i;
  assign is_divmod_in = (opcode_i == OP_DIV) || (opcode_i == OP_MOD);

  assign iter_op = ((op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD)) && !dz_q;
  assign finish  = !iter_op || (cnt_q == CW'(N));

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV/MOD
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, x_q} : '0);
    rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    div_diff = rem_sh - {1'b0, x_q};
    div_ge   = ~div_diff[N];
    if (op_q == OP_MUL)
      acc_next = {mul_sum, acc_q[N-1:1]};
    else
      acc_next = {(div_ge ? div_diff[N-1:0] : rem_sh[N-1:0]), acc_q[N-2:0], div_ge};
  end

  always_comb begin
    add_sum    = {1'b0, a_q} + {1'b0, b_q};
    sub_diff   = {1'b0, a_q} - {1'b0, b_q};
    product    = neg_res_q ? -acc_q : acc_q;
    mul_hi     = product[2*N-1:N-1];
    fin_result = '0;
    fin_ovf    = 1'b0;
    fin_cout   = 1'b0;
    fin_dz     = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_result = add_sum[N-1:0];
        fin_cout   = add_sum[N];
        fin_ovf    = (a_q[N-1] == b_q[N-1]) && (add_sum[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        fin_result = sub_diff[N-1:0];
        fin_cout   = sub_diff[N];
        fin_ovf    = (a_q[N-1] != b_q[N-1]) && (sub_diff[N-1] != a_q[N-1]);
      end
      OP_MUL: begin
        fin_result = product[N-1:0];
        fin_ovf    = sgn_q ? !((&mul_hi) || !(|mul_hi)) : |product[2*N-1:N];
      end
      OP_DIV: begin
        if (dz_q) begin
          fin_result = '1;
          fin_dz     = 1'b1;
        end else begin
          fin_result = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
          fin_ovf    = min_neg_q;
        end
      end
      OP_MOD: begin
        if (dz_q) begin
          fin_result = a_q;
          fin_dz     = 1'b1;
        end else begin
          fin_result = a_neg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
          fin_ovf    = min_neg_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (finish) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
  end

  assign result_o   = result_q;
  assign overflow_o = ovf_q;
  assign cout_o     = cout_q;
  assign div_zero_o = dz_out_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      a_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      min_neg_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q       <= a_i;
        b_q       <= b_i;
        op_q      <= opcode_i;
        sgn_q     <= signed_i;
        neg_res_q <= a_neg_in ^ b_neg_in;
        a_neg_q   <= a_neg_in;
        dz_q      <= is_divmod_in && (b_i == '0);
        min_neg_q <= signed_i && (a_i == MIN_VAL) && (b_i == '1);
        cnt_q     <= '0;
        x_q       <= (opcode_i == OP_MUL) ? mag_a_in : mag_b_in;
        acc_q     <= {{N{1'b0}}, ((opcode_i == OP_MUL) ? mag_b_in : mag_a_in)};
      end
      if (state_q == BUSY) begin
        if (finish) begin
          result_q <= fin_result;
          ovf_q    <= fin_ovf;
          cout_q   <= fin_cout;
          dz_out_q <= fin_dz;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_arith_unit_seq.sv
// tb/tb_arith_unit_seq.sv - randomized and directed checks of arith_unit_seq against a behavioural model
module tb_arith_unit_seq;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_i, signed_i;
  logic [N-1:0]  a_i, b_i;
  logic [2:0]    opcode_i;
  logic          ready_o, valid_o, overflow_o, cout_o, div_zero_o;
  logic [N-1:0]  result_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  arith_unit_seq #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .opcode_i(opcode_i), .signed_i(signed_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .overflow_o(overflow_o), .cout_o(cout_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs straight from arithmetic on wide integers
  function automatic void ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic s, output logic [15:0] r, output logic ov,
                                    output logic co, output logic dz, output int lat);
    longint ua, ub, sa, sb, t;
    logic [63:0] tv;
    ua = longint'({48'b0, a});
    ub = longint'({48'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = 0; r = 0; ov = 0; co = 0; dz = 0; lat = 1;
    case (op)
      3'd0: begin
        t = ua + ub; co = (t > 65535);
        ov = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1: begin
        t = ua - ub; co = (ua < ub);
        ov = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd3: begin
        lat = 17;
        if (s) begin t = sa * sb; ov = (t > 32767) || (t < -32768); end
        else begin t = ua * ub; ov = (t > 65535); end
      end
      3'd2, 3'd4: begin
        if (b == 16'h0) begin
          dz = 1;
          t = (op == 3'd2) ? 64'hFFFF : ua;
        end else begin
          lat = 17;
          if (s) begin
            t = (op == 3'd2) ? sa / sb : sa % sb;
            ov = (sa == -32768) && (sb == -1);
          end else begin
            t = (op == 3'd2) ? ua / ub : ua % ub;
          end
        end
      end
      default: t = 0;
    endcase
    tv = t;
    r = tv[15:0];
  endfunction

  logic        m_busy = 1'b0;
  logic        m_rst = 1'b1;
  logic        exp_valid;
  int          m_due = 0;
  int          m_lat;
  logic [15:0] m_r;
  logic        m_ov, m_co, m_dz;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_valid = m_busy && (cyc >= m_due);
      chk("valid_o", valid_o, exp_valid);
      chk("ready_o", ready_o, !m_busy);
      if (exp_valid) begin
        chk("result_o", result_o, m_r);
        chk("overflow_o", overflow_o, m_ov);
        chk("cout_o", cout_o, m_co);
        chk("div_zero_o", div_zero_o, m_dz);
      end
      if (m_rst) begin
        chk("reset_result", result_o, 0);
        chk("reset_flags", {overflow_o, cout_o, div_zero_o}, 0);
        m_rst = 1'b0;
      end
      if (rst_i) begin
        m_busy = 1'b0;
        m_rst = 1'b1;
      end else if (m_busy && exp_valid && ready_i) begin
        m_busy = 1'b0;
      end else if (!m_busy && valid_i) begin
        ref_model(opcode_i, a_i, b_i, signed_i, m_r, m_ov, m_co, m_dz, m_lat);
        m_busy = 1'b1;
        m_due = cyc + 1 + m_lat;
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int hold, output logic [15:0] r, output logic ov,
                        output logic co, output logic dz, output int lat);
    int acc_cyc;
    bit got;
    r = 0; ov = 0; co = 0; dz = 0; lat = -1; acc_cyc = 0;
    @(posedge clk); #1;
    opcode_i = op; a_i = a; b_i = b; signed_i = s; valid_i = 1'b1; ready_i = (hold == 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ready_o) begin got = 1; acc_cyc = cyc + 1; end
    end
    @(posedge clk); #1;
    valid_i = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom); opcode_i = 3'($urandom);
    if (!got) begin chk("accept_timeout", 0, 1); ready_i = 1'b1; return; end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (valid_o) begin
        got = 1; lat = cyc - acc_cyc;
        r = result_o; ov = overflow_o; co = cout_o; dz = div_zero_o;
      end
    end
    if (!got) begin chk("result_timeout", 0, 1); ready_i = 1'b1; return; end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        valid_i = (i % 2 == 0);
        a_i = 16'($urandom);
      end
      @(posedge clk); #1;
      valid_i = 1'b0; ready_i = 1'b1;
      @(negedge clk);
      chk("hold_valid", valid_o, 1);
      chk("hold_ready", ready_o, 0);
      chk("hold_result", result_o, r);
      chk("hold_flags", {overflow_o, cout_o, div_zero_o}, {ov, co, dz});
    end
  endtask

  task automatic lit(input string name, input logic [2:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic s, input logic [15:0] er, input logic eov,
                     input logic eco, input logic edz, input int elat, input int hold);
    logic [15:0] r;
    logic ov, co, dz;
    int lat;
    run_op(op, a, b, s, hold, r, ov, co, dz, lat);
    chk(name, r, er);
    chk({name, "_flags"}, {ov, co, dz}, {eov, eco, edz});
    chk({name, "_lat"}, lat, elat);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic ov, co, dz, seen;
    int lat;
    rst_i = 1; valid_i = 0; ready_i = 1; a_i = 0; b_i = 0; opcode_i = 0; signed_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;

    ref_model(3'd2, 16'hFFF9, 16'h0002, 1'b1, r, ov, co, dz, lat);
    chk("model_sdiv", {r, ov, dz}, {16'hFFFD, 1'b0, 1'b0});
    ref_model(3'd4, 16'hFFF9, 16'h0002, 1'b1, r, ov, co, dz, lat);
    chk("model_smod", r, 16'hFFFF);
    ref_model(3'd3, 16'hFFFE, 16'h0003, 1'b1, r, ov, co, dz, lat);
    chk("model_smul", {r, ov}, {16'hFFFA, 1'b0});
    ref_model(3'd0, 16'h7FFF, 16'h0001, 1'b0, r, ov, co, dz, lat);
    chk("model_add", {r, ov, co, lat[4:0]}, {16'h8000, 1'b1, 1'b0, 5'd1});

    lit("add_ovf",   3'd0, 16'h7FFF, 16'h0001, 0, 16'h8000, 1, 0, 0, 1, 0);
    lit("add_carry", 3'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 0, 1, 0, 1, 0);
    lit("sub_borrow",3'd1, 16'h0003, 16'h0005, 0, 16'hFFFE, 0, 1, 0, 1, 0);
    lit("sub_ovf",   3'd1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 0, 0, 1, 0);
    lit("mul_u_ovf", 3'd3, 16'h0100, 16'h0100, 0, 16'h0000, 1, 0, 0, 17, 0);
    lit("mul_s",     3'd3, 16'hFFFE, 16'h0003, 1, 16'hFFFA, 0, 0, 0, 17, 5);
    lit("div_u",     3'd2, 16'd100,  16'd7,    0, 16'd14,   0, 0, 0, 17, 0);
    lit("mod_u",     3'd4, 16'd100,  16'd7,    0, 16'd2,    0, 0, 0, 17, 0);
    lit("div_s",     3'd2, 16'hFFF9, 16'h0002, 1, 16'hFFFD, 0, 0, 0, 17, 0);
    lit("mod_s",     3'd4, 16'hFFF9, 16'h0002, 1, 16'hFFFF, 0, 0, 0, 17, 0);
    lit("div_minneg",3'd2, 16'h8000, 16'hFFFF, 1, 16'h8000, 1, 0, 0, 17, 0);
    lit("div_zero",  3'd2, 16'h1234, 16'h0000, 0, 16'hFFFF, 0, 0, 1, 1, 0);
    lit("mod_zero",  3'd4, 16'h1234, 16'h0000, 0, 16'h1234, 0, 0, 1, 1, 2);
    lit("bad_op",    3'd6, 16'h1234, 16'h5678, 1, 16'h0000, 0, 0, 0, 1, 0);

    // MUL interrupted by reset partway through its iterations
    @(posedge clk); #1;
    opcode_i = 3'd3; a_i = 16'h0123; b_i = 16'h0456; signed_i = 0; valid_i = 1; ready_i = 1;
    @(posedge clk); #1 valid_i = 0;
    repeat (7) @(posedge clk);
    #1 rst_i = 1;
    @(posedge clk); #1 rst_i = 0;
    @(negedge clk);
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_ready", ready_o, 1);
    chk("rst_mid_result", result_o, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    chk("rst_no_late_result", seen, 0);

    for (int t = 0; t < 250; t++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), r, ov, co, dz, lat);
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
Parametrised sequential successor to the team's combinational arithmetic unit. Performs ADD/SUB in one cycle and MUL/DIV/MOD as N-step iterative operations, with signed/unsigned mode, divide-by-zero detection and valid/ready handshakes on both sides. Sits between the operand register file and the result writeback stage of the lab ALU datapath.

Parameters:
N, 16, operand and result width in bits (N >= 4)
CW, $clog2(N+1), iteration counter width (derived, not overridden)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  operands/opcode presented
ready_o  out  1  unit can accept a new operation
a_i  in  N  operand A (dividend for DIV/MOD)
b_i  in  N  operand B (divisor for DIV/MOD)
opcode_i  in  3  000 ADD, 001 SUB, 010 DIV, 011 MUL, 100 MOD, others invalid
signed_i  in  1  1 = two's-complement operation, 0 = unsigned
valid_o  out  1  result and flags valid
ready_i  in  1  consumer accepts result
result_o  out  N  result
overflow_o  out  1  overflow (per-op definition below)
cout_o  out  1  ADD carry-out / SUB borrow
div_zero_o  out  1  DIV/MOD with b_i == 0

Behaviour:
- Reset (rst_i high at an edge): FSM -> IDLE; ready_o=1, valid_o=0, result_o=0, all flags 0. Applies mid-operation: current op discarded, no valid_o pulse.
- States: IDLE (ready_o=1), BUSY (iterating), DONE (valid_o=1). ready_o=0 in BUSY and DONE.
- Accept: valid_i && ready_o at edge k latches a_i, b_i, opcode_i, signed_i. Inputs ignored otherwise.
- Latency: ADD/SUB/invalid opcode/div-by-zero -> IDLE->DONE, valid_o high after edge k+1. MUL/DIV/MOD -> BUSY for N iterations, valid_o high after edge k+N+1.
- DONE: result_o and flags held stable while ready_i=0. valid_o && ready_i at an edge -> IDLE; the next op is accepted no earlier than the following edge (no overlap).
- ADD: result = (a+b) mod 2^N; cout_o = bit N of unsigned sum; overflow_o = signed overflow (operands same sign, result sign differs), reported regardless of signed_i.
- SUB: result = (a-b) mod 2^N; cout_o = 1 iff a < b unsigned (borrow); overflow_o = operand signs differ and result sign != a sign.
- MUL: shift-add over N cycles, 2N-bit product, result = low N bits. Unsigned: overflow_o = high half != 0. Signed: operate on magnitudes, negate if signs differ; overflow_o = high N+1 bits not all equal. cout_o=0.
- DIV/MOD: restoring division over N cycles on magnitudes. Signed: quotient truncated toward zero, negated if signs differ; remainder takes dividend sign. Signed MIN / -1: quotient = MIN, remainder 0, overflow_o=1. cout_o=0.
- Divide by zero: detected at accept; DIV result = all ones, MOD result = a_i; div_zero_o=1, overflow_o=0; single-cycle path.
- Invalid opcode: result 0, all flags 0, single-cycle path.
- Flags not defined for an op are 0; div_zero_o is 0 except for a div-by-zero op.
- valid_i while busy: ignored, not queued; the producer must hold valid_i until ready_o.

Test Plan:
- N=16 ADD 0x7FFF+0x0001, ready_i=1 -> valid_o one cycle after accept, result 0x8000, overflow_o=1, cout_o=0; ADD 0xFFFF+0x0001 -> 0x0000, cout_o=1, overflow_o=0.
- SUB 0x0003-0x0005 -> 0xFFFE, cout_o=1, overflow_o=0; SUB 0x8000-0x0001 -> 0x7FFF, overflow_o=1.
- MUL unsigned 0x0100*0x0100 -> 0x0000, overflow_o=1, valid_o exactly 17 cycles after accept; signed 0xFFFE*0x0003 -> 0xFFFA, overflow_o=0.
- DIV unsigned 100/7 -> 14, MOD -> 2; signed 0xFFF9/0x0002 -> 0xFFFD, MOD -> 0xFFFF; signed 0x8000/0xFFFF -> 0x8000, overflow_o=1.
- DIV 0x1234/0 -> 0xFFFF, div_zero_o=1, latency 1; MOD 0x1234/0 -> 0x1234, div_zero_o=1.
- Hold ready_i=0 for 5 cycles in DONE -> result/flags stable, ready_o=0, pulsed valid_i ignored. Assert rst_i on cycle 8 of a MUL -> next cycle valid_o=0, ready_o=1, result_o=0, no late result.
